// File: rtl/spi_slave_tx.sv
// Transmit shifter of the SPI slave. It sends a parallel word MSB-first on sdo0 (single mode)
// or on sdo3..sdo0 (quad mode). All state changes happen on the falling edge of sclk.
module spi_slave_tx #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              sclk,
    input  logic              cs,
    input  logic              en_quad_in,
    input  logic [CNT_W-1:0]  counter_in,
    input  logic              counter_in_upd,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    output logic              sdo0,
    output logic              sdo1,
    output logic              sdo2,
    output logic              sdo3,
    output logic              is_ready,
    output logic              tx_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TRGT_RST = CNT_W'(DATA_W - 1);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] data_int, data_nxt;
    logic [CNT_W-1:0]  counter, counter_nxt;
    logic [CNT_W-1:0]  counter_trgt, trgt_nxt;
    logic              quad, quad_nxt;
    logic              load;
    logic [3:0]        sdo;

    // cs high deselects the slave and abandons any word in flight.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(negedge sclk or posedge cs) begin
        if (cs) begin
            state        <= IDLE;
            data_int     <= '0;
            counter      <= '0;
            quad         <= 1'b0;
            counter_trgt <= TRGT_RST;
        end else begin
            state        <= state_nxt;
            data_int     <= data_nxt;
            counter      <= counter_nxt;
            quad         <= quad_nxt;
            counter_trgt <= trgt_nxt;
        end
    end

    assign tx_done  = (state == SHIFT) && (counter == counter_trgt);
    assign is_ready = (state == IDLE) || tx_done;
    assign load     = data_valid && is_ready;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path leaves one unassigned and no latch is inferred.
        state_nxt   = state;
        data_nxt    = data_int;
        counter_nxt = counter;
        quad_nxt    = quad;
        trgt_nxt    = counter_trgt;

        if (load) begin
            data_nxt    = data;
            quad_nxt    = en_quad_in;
            counter_nxt = '0;
            state_nxt   = SHIFT;
        end else if (state == SHIFT) begin
            if (tx_done) begin
                state_nxt   = IDLE;
                counter_nxt = '0;
            end else begin
                data_nxt    = quad ? (data_int << 4) : (data_int << 1);
                counter_nxt = counter + CNT_W'(1);
            end
        end

        // The target changes only between words, so the word on the line is never truncated.
        if (counter_in_upd && is_ready)
            trgt_nxt = counter_in;
    end

    always_comb begin
        sdo = 4'b0000;
        if (state == SHIFT) begin
            if (quad)
                sdo = data_int[DATA_W-1 -: 4];
            else
                sdo = {3'b000, data_int[DATA_W-1]};
        end
    end

    assign sdo0 = sdo[0];
    assign sdo1 = sdo[1];
    assign sdo2 = sdo[2];
    assign sdo3 = sdo[3];

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed bench for spi_slave_tx. Inputs are driven, and outputs are sampled, 1 ns after each falling sclk edge.
module tb_spi_slave_tx;

    logic        sclk = 1'b1;
    logic        cs = 1'b1;
    logic        en_quad_in = 1'b0;
    logic [7:0]  counter_in = '0;
    logic        counter_in_upd = 1'b0;
    logic [31:0] data = '0;
    logic        data_valid = 1'b0;
    logic        sdo0, sdo1, sdo2, sdo3, is_ready, tx_done;

    int checks = 0;
    int failures = 0;

    spi_slave_tx #(.DATA_W(32), .CNT_W(8)) dut (
        .sclk           (sclk),
        .cs             (cs),
        .en_quad_in     (en_quad_in),
        .counter_in     (counter_in),
        .counter_in_upd (counter_in_upd),
        .data           (data),
        .data_valid     (data_valid),
        .sdo0           (sdo0),
        .sdo1           (sdo1),
        .sdo2           (sdo2),
        .sdo3           (sdo3),
        .is_ready       (is_ready),
        .tx_done        (tx_done)
    );

    always #5 sclk = ~sclk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // The observed vector is {sdo3, sdo2, sdo1, sdo0, tx_done, is_ready}.
    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {sdo3, sdo2, sdo1, sdo0, tx_done, is_ready};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic fall();
        @(negedge sclk);
        #1;
    endtask

    function automatic logic [3:0] exp_sdo(input logic [31:0] w, input logic q, input int k);
        if (q) return (k < 8) ? w[31-4*k -: 4] : 4'b0000;
        return (k < 32) ? {3'b000, w[31-k]} : 4'b0000;
    endfunction

    // After this returns, beat 1 of the word is on the line.
    task automatic do_load(input logic [31:0] w, input logic q, input logic upd, input logic [7:0] cin);
        data           = w;
        en_quad_in     = q;
        data_valid     = 1'b1;
        counter_in_upd = upd;
        counter_in     = cin;
        fall();
        data_valid     = 1'b0;
        counter_in_upd = 1'b0;
    endtask

    // Checks nbeats beats of a word whose first beat is already visible. If chain is set,
    // the next word is presented during the last beat; otherwise the return to IDLE is checked.
    task automatic check_word(input string tag, input logic [31:0] w, input logic q, input int nbeats,
                              input logic chain, input logic [31:0] nw, input logic nq,
                              input int upd_at, input logic [7:0] cin);
        logic last;
        for (int k = 0; k < nbeats; k++) begin
            if (k > 0) fall();
            if (k == upd_at + 1) counter_in_upd = 1'b0;
            last = (k == nbeats - 1);
            chk($sformatf("%s_beat%0d", tag, k + 1), {exp_sdo(w, q, k), last, last});
            if (k == upd_at) begin
                counter_in_upd = 1'b1;
                counter_in     = cin;
            end
            if (last && chain) begin
                data       = nw;
                en_quad_in = nq;
                data_valid = 1'b1;
            end
        end
        fall();
        data_valid = 1'b0;
        if (!chain) chk({tag, "_idle"}, 6'b0000_01);
    endtask

    initial begin
        // Reset while cs is high.
        #2;
        chk("reset", 6'b0000_01);
        fall();
        fall();
        cs = 1'b0;
        fall();
        fall();
        chk("idle_hold", 6'b0000_01);

        // 1: single mode, default target of 31.
        do_load(32'hA5A5_F00F, 1'b0, 1'b0, 8'd0);
        check_word("single", 32'hA5A5_F00F, 1'b0, 32, 1'b0, 32'h0, 1'b0, -1, 8'd0);

        // 3: back-to-back words with no idle beat between them.
        do_load(32'hFFFF_0000, 1'b0, 1'b0, 8'd0);
        check_word("b2b_a", 32'hFFFF_0000, 1'b0, 32, 1'b1, 32'h0000_FFFF, 1'b0, -1, 8'd0);
        check_word("b2b_b", 32'h0000_FFFF, 1'b0, 32, 1'b0, 32'h0, 1'b0, -1, 8'd0);

        // 2: quad mode, target 7 written together with the load.
        do_load(32'h1234_5678, 1'b1, 1'b1, 8'd7);
        check_word("quad", 32'h1234_5678, 1'b1, 8, 1'b0, 32'h0, 1'b0, -1, 8'd0);

        // 4: target stays at 7 for a short single-mode word.
        do_load(32'hC312_3456, 1'b0, 1'b0, 8'd0);
        check_word("short", 32'hC312_3456, 1'b0, 8, 1'b0, 32'h0, 1'b0, -1, 8'd0);

        // 5: target 20, then abort the word with cs after 10 beats.
        do_load(32'hDEAD_BEEF, 1'b0, 1'b1, 8'd20);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) fall();
            chk($sformatf("abort_beat%0d", k + 1), {exp_sdo(32'hDEAD_BEEF, 1'b0, k), 2'b00});
        end
        cs = 1'b1;
        #1;
        chk("abort_cs", 6'b0000_01);
        fall();
        cs = 1'b0;
        fall();
        chk("abort_idle", 6'b0000_01);
        do_load(32'h8000_0001, 1'b0, 1'b0, 8'd0);
        check_word("after_cs", 32'h8000_0001, 1'b0, 32, 1'b0, 32'h0, 1'b0, -1, 8'd0);

        // 6: a target write during beat 5 is ignored; the next word still takes 32 beats.
        do_load(32'h5A5A_3C3C, 1'b0, 1'b0, 8'd0);
        check_word("ign_upd", 32'h5A5A_3C3C, 1'b0, 32, 1'b0, 32'h0, 1'b0, 4, 8'd3);
        do_load(32'h0F0F_0F0F, 1'b0, 1'b0, 8'd0);
        check_word("trgt_kept", 32'h0F0F_0F0F, 1'b0, 32, 1'b0, 32'h0, 1'b0, -1, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
